uart_echo_top: RTL

Parametrised UART top level: oversampled receiver, transmitter, baud generator, button edge detector and a receive FIFO between RX and TX. Received bytes are queued and either echoed automatically or released one per button press. Frame width, baud rate and queue depth are set at elaboration. An optional parity bit is selected at compile time. It sits at the board pin level in place of the fixed 8-bit, single-register UART top.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_echo_if.sv | 28 ++
 rtl/uart_sync_fifo.sv | 52 +++++
 rtl/uart_echo_top.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types: RX/TX state enums, line-level constants and the baud divisor helper.
// Optional feature macro: UART_PARITY_EN adds the even-parity state to both FSMs.
package uart_pkg;

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
`else
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
`endif

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Rounded clocks per oversample tick, never below one.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        int div;
        div = (clk_hz + (baud * os) / 2) / (baud * os);
        return (div < 1) ? 1 : div;
    endfunction

endpackage

// File: rtl/uart_echo_if.sv
// Board-pin bundle of the UART echo block: serial lines, user controls and status outputs.
interface uart_echo_if #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic                 button;
    logic                 echo_en;
    logic                 rxd;
    logic                 txd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overflow;
    logic [CNT_W-1:0]     fifo_count;

    modport master (
        output button, echo_en, rxd,
        input  txd, rx_data, rx_valid, frame_err, parity_err, overflow, fifo_count
    );

    modport slave (
        input  button, echo_en, rxd,
        output txd, rx_data, rx_valid, frame_err, parity_err, overflow, fifo_count
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; read data is registered on pop.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = DEPTH[CW-1:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= push_data;
        if (do_pop)  pop_data  <= mem[rptr];
    end
endmodule

// File: rtl/uart_echo_top.sv
// UART echo top: oversampled RX into a FIFO, TX released automatically or per button press.
// Optional feature macro: UART_PARITY_EN (even parity on TX, checked on RX).
module uart_echo_top import uart_pkg::*; #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input logic  clk,
    input logic  reset,
    uart_echo_if.slave bus
);
    localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [OW-1:0] OS_LAST  = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_MID   = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic          rxd_p0, rxd_p1, rxd_p2;
    logic          btn_p0, btn_p1, btn_p2;
    logic          rxd_fall, btn_rise;

    assign tick = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            rxd_p0  <= LINE_IDLE;
            rxd_p1  <= LINE_IDLE;
            rxd_p2  <= LINE_IDLE;
            btn_p0  <= 1'b0;
            btn_p1  <= 1'b0;
            btn_p2  <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
            rxd_p0  <= bus.rxd;
            rxd_p1  <= rxd_p0;
            rxd_p2  <= rxd_p1;
            btn_p0  <= bus.button;
            btn_p1  <= btn_p0;
            btn_p2  <= btn_p1;
        end
    end

    assign rxd_fall = rxd_p2 && !rxd_p1;
    assign btn_rise = btn_p1 && !btn_p2;

    // ---------------- receiver ----------------
    rx_state_t            rx_state, rx_next;
    logic [OW-1:0]        rx_cnt, rx_cnt_next;
    logic [BW-1:0]        rx_bit, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift, rx_shift_next;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 good_next, ferr_next;
    logic                 rx_valid_q, frame_err_q;
`ifdef UART_PARITY_EN
    logic                 rx_par, rx_par_next;
    logic                 perr_next, parity_err_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_bit      <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_state    <= rx_next;
            rx_cnt      <= rx_cnt_next;
            rx_bit      <= rx_bit_next;
            rx_valid_q  <= good_next;
            frame_err_q <= ferr_next;
            if (good_next) rx_data_q <= rx_shift;
        end
        rx_shift <= rx_shift_next;
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) parity_err_q <= 1'b0;
        else       parity_err_q <= perr_next;
        rx_par <= rx_par_next;
    end
`endif

    always_comb begin
        rx_next       = rx_state;
        rx_cnt_next   = rx_cnt;
        rx_bit_next   = rx_bit;
        rx_shift_next = rx_shift;
        good_next     = 1'b0;
        ferr_next     = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_next   = rx_par;
        perr_next     = 1'b0;
`endif
        case (rx_state)
            RX_IDLE: begin
                if (rxd_fall) begin
                    rx_next     = RX_START;
                    rx_cnt_next = '0;
                end
            end
            RX_START: begin
                if (tick) begin
                    if (rx_cnt == OS_MID) begin
                        // A start bit that is high again at mid-bit was a glitch.
                        rx_cnt_next = '0;
                        rx_bit_next = '0;
                        rx_next     = rxd_p1 ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_next = rx_cnt + OW'(1);
                    end
                end
            end
            RX_DATA: begin
                if (tick) begin
                    if (rx_cnt == OS_LAST) begin
                        rx_cnt_next   = '0;
                        rx_shift_next = {rxd_p1, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            rx_next = RX_PARITY;
`else
                            rx_next = RX_STOP;
`endif
                        end else begin
                            rx_bit_next = rx_bit + BW'(1);
                        end
                    end else begin
                        rx_cnt_next = rx_cnt + OW'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            RX_PARITY: begin
                if (tick) begin
                    if (rx_cnt == OS_LAST) begin
                        rx_cnt_next = '0;
                        rx_par_next = rxd_p1;
                        rx_next     = RX_STOP;
                    end else begin
                        rx_cnt_next = rx_cnt + OW'(1);
                    end
                end
            end
`endif
            RX_STOP: begin
                if (tick) begin
                    if (rx_cnt == OS_LAST) begin
                        rx_cnt_next = '0;
                        rx_next     = RX_IDLE;
                        ferr_next   = (rxd_p1 != STOP_BIT);
`ifdef UART_PARITY_EN
                        perr_next   = ((^rx_shift) != rx_par);
                        good_next   = (rxd_p1 == STOP_BIT) && ((^rx_shift) == rx_par);
`else
                        good_next   = (rxd_p1 == STOP_BIT);
`endif
                    end else begin
                        rx_cnt_next = rx_cnt + OW'(1);
                    end
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // ---------------- queue ----------------
    logic [DATA_BITS-1:0] pop_data;
    logic                 fifo_full, fifo_empty, pop, overflow_q;
    logic [CW-1:0]        fifo_count;
    tx_state_t            tx_state, tx_next;

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_valid_q),
        .push_data (rx_data_q),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Button edges outside an idle, non-empty window simply fall through.
    assign pop = (tx_state == TX_IDLE) && !fifo_empty && (bus.echo_en || btn_rise);

    always_ff @(posedge clk) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_q || (rx_valid_q && fifo_full && !pop);
    end

    // ---------------- transmitter ----------------
    logic [OW-1:0] tx_cnt, tx_cnt_next;
    logic [BW-1:0] tx_bit, tx_bit_next;
    logic          tx_go, tx_go_next;
    logic          txd_q, txd_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_go    <= 1'b0;
            txd_q    <= LINE_IDLE;
        end else begin
            tx_state <= tx_next;
            tx_cnt   <= tx_cnt_next;
            tx_bit   <= tx_bit_next;
            tx_go    <= tx_go_next;
            txd_q    <= txd_next;
        end
    end

    // pop_data stays stable for the whole frame, so bits are read from it directly.
    always_comb begin
        tx_next     = tx_state;
        tx_cnt_next = tx_cnt;
        tx_bit_next = tx_bit;
        tx_go_next  = tx_go;
        txd_next    = txd_q;
        case (tx_state)
            TX_IDLE: begin
                txd_next = LINE_IDLE;
                if (pop) begin
                    tx_next    = TX_START;
                    tx_go_next = 1'b0;
                end
            end
            TX_START: begin
                if (tick) begin
                    if (!tx_go) begin
                        tx_go_next  = 1'b1;
                        tx_cnt_next = '0;
                        txd_next    = START_BIT;
                    end else if (tx_cnt == OS_LAST) begin
                        tx_cnt_next = '0;
                        tx_bit_next = '0;
                        tx_next     = TX_DATA;
                        txd_next    = pop_data[0];
                    end else begin
                        tx_cnt_next = tx_cnt + OW'(1);
                    end
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (tx_cnt == OS_LAST) begin
                        tx_cnt_next = '0;
                        if (tx_bit == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            tx_next  = TX_PARITY;
                            txd_next = ^pop_data;
`else
                            tx_next  = TX_STOP;
                            txd_next = STOP_BIT;
`endif
                        end else begin
                            tx_bit_next = tx_bit + BW'(1);
                            txd_next    = pop_data[tx_bit + BW'(1)];
                        end
                    end else begin
                        tx_cnt_next = tx_cnt + OW'(1);
                    end
                end
            end
`ifdef UART_PARITY_EN
            TX_PARITY: begin
                if (tick) begin
                    if (tx_cnt == OS_LAST) begin
                        tx_cnt_next = '0;
                        tx_next     = TX_STOP;
                        txd_next    = STOP_BIT;
                    end else begin
                        tx_cnt_next = tx_cnt + OW'(1);
                    end
                end
            end
`endif
            TX_STOP: begin
                if (tick) begin
                    if (tx_cnt == OS_LAST) begin
                        tx_cnt_next = '0;
                        tx_next     = TX_IDLE;
                        txd_next    = LINE_IDLE;
                    end else begin
                        tx_cnt_next = tx_cnt + OW'(1);
                    end
                end
            end
            default: begin
                tx_next  = TX_IDLE;
                txd_next = LINE_IDLE;
            end
        endcase
    end

    assign bus.txd        = txd_q;
    assign bus.rx_data    = rx_data_q;
    assign bus.rx_valid   = rx_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_count = fifo_count;
`ifdef UART_PARITY_EN
    assign bus.parity_err = parity_err_q;
`else
    assign bus.parity_err = 1'b0;
`endif
endmodule
